warp_fetch_scheduler: RTL and testbench

- Per-warp fetch controller that sits in front of the instruction cache / decoder pipeline of a compute unit.
- Holds PC, active mask and state for every warp, and launches new warps.
- Picks one ready warp per cycle by round-robin and issues its PC toward the instruction cache.
- Re-arms or retires each warp from the decoder's decoded / next-PC / stop feedback, so each warp has at most one instruction in flight.

---
 rtl/warp_fetch_scheduler.sv | 145 ++++++++++++++
 tb/tb_warp_fetch_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_fetch_scheduler.sv
// Per-warp fetch scheduler: launches warps, round-robin issues one READY warp's PC to the
// instruction cache, and re-arms or retires warps from decoder feedback.
module warp_fetch_scheduler #(
    parameter int PcWidth   = 32,
    parameter int NumWarps  = 8,
    parameter int WarpWidth = 32,
    parameter int WidWidth  = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_valid_i,
    output logic                 start_ready_o,
    input  logic [PcWidth-1:0]   start_pc_i,
    input  logic [WarpWidth-1:0] start_act_mask_i,
    output logic [WidWidth-1:0]  start_wid_o,
    output logic                 fe_valid_o,
    input  logic                 ic_ready_i,
    output logic [PcWidth-1:0]   fe_pc_o,
    output logic [WarpWidth-1:0] fe_act_mask_o,
    output logic [WidWidth-1:0]  fe_warp_id_o,
    input  logic                 dec_decoded_i,
    input  logic                 dec_stop_warp_i,
    input  logic [WidWidth-1:0]  dec_decoded_warp_id_i,
    input  logic [PcWidth-1:0]   dec_decoded_next_pc_i,
    output logic                 all_idle_o
);

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_READY = 2'd1,
        W_WAIT  = 2'd2
    } warp_state_e;

    warp_state_e          state_q [NumWarps];
    logic [PcWidth-1:0]   pc_q    [NumWarps];
    logic [WarpWidth-1:0] mask_q  [NumWarps];
    logic [WidWidth-1:0]  rr_q;
    logic [WidWidth-1:0]  lock_wid_q;
    logic                 lock_q;

    logic                 any_idle;
    logic                 all_idle;
    logic [WidWidth-1:0]  idle_wid;
    logic                 any_ready;
    logic [WidWidth-1:0]  grant_wid;
    logic [WidWidth-1:0]  sel_wid;
    logic                 handshake;
    logic                 dec_hit;
    logic                 launch;
    int                   scan_idx;

    // Descending scan leaves the lowest-index IDLE warp as the launch slot.
    always_comb begin
        any_idle = 1'b0;
        all_idle = 1'b1;
        idle_wid = '0;
        for (int i = NumWarps - 1; i >= 0; i--) begin
            if (state_q[i] == W_IDLE) begin
                any_idle = 1'b1;
                idle_wid = WidWidth'(i);
            end else begin
                all_idle = 1'b0;
            end
        end
    end

    always_comb begin
        any_ready = 1'b0;
        grant_wid = '0;
        scan_idx  = 0;
        for (int i = 0; i < NumWarps; i++) begin
            scan_idx = (int'(rr_q) + i) % NumWarps;
            if (!any_ready && state_q[WidWidth'(scan_idx)] == W_READY) begin
                any_ready = 1'b1;
                grant_wid = WidWidth'(scan_idx);
            end
        end
    end

    // A stalled offer stays pinned to its warp so the cache sees a stable request.
    assign sel_wid       = lock_q ? lock_wid_q : grant_wid;
    assign fe_valid_o    = any_ready | lock_q;
    assign fe_pc_o       = pc_q[sel_wid];
    assign fe_act_mask_o = mask_q[sel_wid];
    assign fe_warp_id_o  = sel_wid;
    assign handshake     = fe_valid_o & ic_ready_i;

    assign start_ready_o = any_idle;
    assign start_wid_o   = idle_wid;
    assign all_idle_o    = all_idle;
    assign launch        = start_valid_i & any_idle;

    assign dec_hit = dec_decoded_i
                  && (int'(dec_decoded_warp_id_i) < NumWarps)
                  && (state_q[dec_decoded_warp_id_i] == W_WAIT);

    // Handshake, decode and launch always hit warps in different states, so they never collide.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumWarps; i++) begin
                state_q[i] <= W_IDLE;
                pc_q[i]    <= '0;
                mask_q[i]  <= '0;
            end
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_wid_q <= '0;
        end else begin
            if (handshake) begin
                state_q[sel_wid] <= W_WAIT;
                rr_q   <= (sel_wid == WidWidth'(NumWarps - 1)) ? '0 : sel_wid + 1'b1;
                lock_q <= 1'b0;
            end else if (fe_valid_o) begin
                lock_q     <= 1'b1;
                lock_wid_q <= sel_wid;
            end
            if (dec_hit) begin
                if (dec_stop_warp_i) begin
                    state_q[dec_decoded_warp_id_i] <= W_IDLE;
                    mask_q[dec_decoded_warp_id_i]  <= '0;
                end else begin
                    state_q[dec_decoded_warp_id_i] <= W_READY;
                    pc_q[dec_decoded_warp_id_i]    <= dec_decoded_next_pc_i;
                end
            end
            if (launch) begin
                state_q[idle_wid] <= W_READY;
                pc_q[idle_wid]    <= start_pc_i;
                mask_q[idle_wid]  <= start_act_mask_i;
            end
        end
    end

`ifndef SYNTHESIS
    a_num_warps: assert property (@(posedge clk_i) NumWarps >= 1);

    a_fe_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (fe_valid_o && !ic_ready_i) |=> (fe_valid_o && $stable(fe_pc_o)
            && $stable(fe_act_mask_o) && $stable(fe_warp_id_o)));

    a_dec_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
        dec_decoded_i |-> dec_hit);
`endif

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Directed bench for warp_fetch_scheduler with a per-warp behavioural model checked every cycle.
module tb_warp_fetch_scheduler;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_valid, start_ready;
    logic [31:0] start_pc, start_mask;
    logic [2:0]  start_wid;
    logic        fe_valid, ic_ready;
    logic [31:0] fe_pc, fe_mask;
    logic [2:0]  fe_wid;
    logic        dec, dec_stop;
    logic [2:0]  dec_wid;
    logic [31:0] dec_pc;
    logic        all_idle;

    int n_vec = 0;
    int n_err = 0;

    warp_fetch_scheduler #(.PcWidth(32), .NumWarps(N), .WarpWidth(32)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .start_valid_i         (start_valid),
        .start_ready_o         (start_ready),
        .start_pc_i            (start_pc),
        .start_act_mask_i      (start_mask),
        .start_wid_o           (start_wid),
        .fe_valid_o            (fe_valid),
        .ic_ready_i            (ic_ready),
        .fe_pc_o               (fe_pc),
        .fe_act_mask_o         (fe_mask),
        .fe_warp_id_o          (fe_wid),
        .dec_decoded_i         (dec),
        .dec_stop_warp_i       (dec_stop),
        .dec_decoded_warp_id_i (dec_wid),
        .dec_decoded_next_pc_i (dec_pc),
        .all_idle_o            (all_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 = idle, 1 = ready, 2 = waiting on decoder.
    int          m_state [N];
    logic [31:0] m_pc    [N];
    logic [31:0] m_mask  [N];
    int          m_last;
    int          m_offer;

    function automatic int exp_grant();
        if (m_offer >= 0) return m_offer;
        for (int k = 1; k <= N; k++)
            if (m_state[(m_last + k) % N] == 1) return (m_last + k) % N;
        return -1;
    endfunction

    function automatic int lowest_idle();
        for (int w = 0; w < N; w++)
            if (m_state[w] == 0) return w;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < N; w++) begin
                m_state[w] = 0;
                m_pc[w]    = '0;
                m_mask[w]  = '0;
            end
            m_last  = N - 1;
            m_offer = -1;
        end else begin
            int g, li;
            int snap [N];
            g    = exp_grant();
            li   = lowest_idle();
            snap = m_state;
            if (g >= 0) begin
                if (ic_ready) begin
                    m_state[g] = 2;
                    m_last     = g;
                    m_offer    = -1;
                end else begin
                    m_offer = g;
                end
            end
            if (dec && snap[dec_wid] == 2) begin
                if (dec_stop) begin
                    m_state[dec_wid] = 0;
                    m_mask[dec_wid]  = '0;
                end else begin
                    m_state[dec_wid] = 1;
                    m_pc[dec_wid]    = dec_pc;
                end
            end
            if (start_valid && li >= 0) begin
                m_state[li] = 1;
                m_pc[li]    = start_pc;
                m_mask[li]  = start_mask;
            end
        end
    end

    always @(negedge clk) begin
        int g, li;
        bit idle_all;
        g  = exp_grant();
        li = lowest_idle();
        idle_all = 1'b1;
        for (int w = 0; w < N; w++)
            if (m_state[w] != 0) idle_all = 1'b0;
        chk("model_start_ready", start_ready, li >= 0);
        if (li >= 0) chk("model_start_wid", start_wid, li);
        chk("model_all_idle", all_idle, idle_all);
        chk("model_fe_valid", fe_valid, g >= 0);
        if (g >= 0) begin
            chk("model_fe_wid", fe_wid, g);
            chk("model_fe_pc", fe_pc, m_pc[g]);
            chk("model_fe_mask", fe_mask, m_mask[g]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        dec         = 1'b0;
        dec_stop    = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int          prev;
        logic [31:0] prev_pc;
        int          exp_g  [8] = '{0, 1, 2, 0, 1, 2, 3, 0};
        logic [31:0] exp_pc [8] = '{32'h200, 32'h300, 32'h400, 32'h204,
                                    32'h304, 32'h404, 32'h500, 32'h208};
        start_valid = 0; start_pc = '0; start_mask = '0;
        ic_ready = 0; dec = 0; dec_stop = 0; dec_wid = '0; dec_pc = '0;
        #1 rst_n = 1'b0;

        @(negedge clk);
        chk("rst_fe_valid", fe_valid, 0);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_all_idle", all_idle, 1);
        chk("rst_start_wid", start_wid, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // First launch and fetch
        start_valid = 1; start_pc = 32'h100; start_mask = '1; ic_ready = 1;
        @(negedge clk);
        chk("s1_start_wid", start_wid, 0);
        chk("s1_start_ready", start_ready, 1);
        tick();
        @(negedge clk);
        chk("s1_fe_valid", fe_valid, 1);
        chk("s1_fe_pc", fe_pc, 32'h100);
        chk("s1_fe_wid", fe_wid, 0);
        chk("s1_fe_mask", fe_mask, 32'hFFFF_FFFF);
        tick();
        @(negedge clk);
        chk("s1_wait_fe_valid", fe_valid, 0);
        chk("s1_wait_all_idle", all_idle, 0);

        // Decoder re-arm, then stop
        dec = 1; dec_wid = 0; dec_pc = 32'h101;
        tick();
        @(negedge clk);
        chk("s2_fe_valid", fe_valid, 1);
        chk("s2_fe_pc", fe_pc, 32'h101);
        tick();
        dec = 1; dec_stop = 1; dec_wid = 0;
        tick();
        @(negedge clk);
        chk("s2_all_idle", all_idle, 1);
        chk("s2_start_wid", start_wid, 0);
        chk("s2_fe_valid", fe_valid, 0);

        // Round-robin over three warps, with warp 3 launched mid-sequence
        ic_ready = 0;
        for (int i = 0; i < 3; i++) begin
            start_valid = 1; start_pc = 32'h200 + 32'(i) * 32'h100; start_mask = 32'(1 << i);
            tick();
        end
        ic_ready = 1;
        prev = -1;
        prev_pc = '0;
        for (int k = 0; k < 8; k++) begin
            if (prev >= 0) begin
                dec = 1; dec_wid = 3'(prev); dec_pc = prev_pc + 32'd4;
            end
            if (k == 5) begin
                start_valid = 1; start_pc = 32'h500; start_mask = 32'hF;
            end
            @(negedge clk);
            if (k == 5) chk("s3_start_wid", start_wid, 3);
            chk("s3_grant", fe_wid, exp_g[k]);
            chk("s3_pc", fe_pc, exp_pc[k]);
            prev    = int'(fe_wid);
            prev_pc = fe_pc;
            tick();
        end

        // Stalled offer stays pinned while another warp becomes ready
        pulse_reset();
        ic_ready = 1;
        start_valid = 1; start_pc = 32'h10; start_mask = 32'h1; tick();
        start_valid = 1; start_pc = 32'h20; start_mask = 32'h2; tick();
        start_valid = 1; start_pc = 32'h30; start_mask = 32'h4; tick();
        ic_ready = 0;
        dec = 1; dec_wid = 0; dec_pc = 32'h14;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s4_hold_valid", fe_valid, 1);
            chk("s4_hold_wid", fe_wid, 2);
            chk("s4_hold_pc", fe_pc, 32'h30);
            tick();
        end
        ic_ready = 1;
        @(negedge clk);
        chk("s4_release_wid", fe_wid, 2);
        tick();
        @(negedge clk);
        chk("s4_next_wid", fe_wid, 0);
        chk("s4_next_pc", fe_pc, 32'h14);
        tick();

        // Fill all slots, then free one by stop alongside a handshake
        pulse_reset();
        ic_ready = 0;
        for (int i = 0; i < N; i++) begin
            start_valid = 1; start_pc = 32'h1000 + 32'(i) * 32'h10; start_mask = 32'(1 << i);
            @(negedge clk);
            chk("s5_fill_wid", start_wid, i);
            tick();
        end
        start_valid = 1; start_pc = 32'hDEAD; ic_ready = 1;
        @(negedge clk);
        chk("s5_full_ready", start_ready, 0);
        chk("s5_grant0", fe_wid, 0);
        tick();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("s5_grant", fe_wid, i);
            tick();
        end
        dec = 1; dec_stop = 1; dec_wid = 5;
        @(negedge clk);
        chk("s5_grant6", fe_wid, 6);
        chk("s5_same_cycle_ready", start_ready, 0);
        tick();
        @(negedge clk);
        chk("s5_freed_ready", start_ready, 1);
        chk("s5_freed_wid", start_wid, 5);
        chk("s5_grant7", fe_wid, 7);

        // Asynchronous reset mid-stream
        #1 rst_n = 1'b0;
        #1;
        chk("s6_async_fe_valid", fe_valid, 0);
        chk("s6_async_all_idle", all_idle, 1);
        chk("s6_async_start_ready", start_ready, 1);
        chk("s6_async_start_wid", start_wid, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        start_valid = 1; start_pc = 32'h7; start_mask = 32'h3;
        tick();
        @(negedge clk);
        chk("s6_relaunch_valid", fe_valid, 1);
        chk("s6_relaunch_pc", fe_pc, 32'h7);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
